coherence_bus_ctrl: RTL and testbench

- Snoopy MSI bus controller sitting directly below the two per-core dcaches and above the data RAM port.
- Arbitrates the caches' two-word block transactions and drives snoops: ccwait, ccinv and ccsnoopaddr to the non-requesting cache.
- Forwards a dirty snooped block to RAM before the requester's read proceeds.
- Returns dwait/dload per cache. Instruction traffic is merged by a separate arbiter below this block.

---
 rtl/coherence_bus_ctrl.sv | 143 ++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Snoopy MSI bus controller between two per-core dcaches and the data RAM
// port. It arbitrates two-word block transactions round-robin and snoops the
// non-requesting cache. A dirty snooped block is written back to RAM before
// the requester's transfer proceeds.
`timescale 1ns/1ps
module coherence_bus_ctrl #(
  parameter int RAM_LAT = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  input  logic [63:0] daddr,
  input  logic [63:0] dstore,
  output logic [1:0]  dwait,
  output logic [63:0] dload,
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [63:0] ccsnoopaddr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {IDLE, SNOOP, SWB, XFER} state_t;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;   // cache currently owning the bus
  logic        last, last_nxt;     // most recent grant, for round-robin
  logic        cnt, cnt_nxt;       // completed words of the current block
  logic        snp_ph, snp_ph_nxt; // second SNOOP cycle marker
  logic        other;              // the snooped (non-granted) cache
  logic [1:0]  req;
  logic [31:0] addr_g, addr_o, store_g, store_o;

  assign req     = dREN | dWEN;
  assign other   = ~grant;
  assign addr_g  = grant ? daddr[63:32]  : daddr[31:0];
  assign addr_o  = grant ? daddr[31:0]   : daddr[63:32];
  assign store_g = grant ? dstore[63:32] : dstore[31:0];
  assign store_o = grant ? dstore[31:0]  : dstore[63:32];

  // Both caches see the raw RAM read data; dwait qualifies it.
  assign dload = {ram_load, ram_load};

  // State, arbitration history and word counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      cnt    <= 1'b0;
      snp_ph <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      snp_ph <= snp_ph_nxt;
    end
  end

  // Next-state logic: grants only in IDLE, so a burst is never interrupted.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last;
    cnt_nxt    = cnt;
    snp_ph_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          if (&req) grant_nxt = ~last;
          else      grant_nxt = req[1];
          last_nxt  = grant_nxt;
          state_nxt = (dREN[grant_nxt] & cctrans[grant_nxt]) ? SNOOP : XFER;
        end
      end
      SNOOP: begin
        // First cycle lets the snoopee look up its tags; decide on the second.
        if (!snp_ph) snp_ph_nxt = 1'b1;
        else         state_nxt  = ccwrite[other] ? SWB : XFER;
      end
      SWB: begin
        if (ram_ready) begin
          if (cnt) state_nxt = XFER;
          else     cnt_nxt   = 1'b1;
        end
      end
      XFER: begin
        // A dropped request ends the block early (e.g. single-word store).
        if (!req[grant]) begin
          state_nxt = IDLE;
        end else if (ram_ready) begin
          if (cnt) state_nxt = IDLE;
          else     cnt_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = 1'b0;
  end

  // Output decode: snoop lines to the other cache, RAM port to whoever moves data.
  always_comb begin
    dwait       = 2'b11;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    case (state)
      SNOOP, SWB: begin
        ccwait[other] = 1'b1;
        ccinv[other]  = ccwrite[grant];
        if (other) ccsnoopaddr[63:32] = addr_g;
        else       ccsnoopaddr[31:0]  = addr_g;
        if (state == SWB) begin
          ram_wen      = dWEN[other];
          ram_addr     = addr_o;
          ram_store    = store_o;
          dwait[other] = ~ram_ready;
        end
      end
      XFER: begin
        ram_ren      = dREN[grant];
        ram_wen      = dWEN[grant] & ~dREN[grant];
        ram_addr     = addr_g;
        ram_store    = store_g;
        dwait[grant] = ~ram_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed, table-driven bench for coherence_bus_ctrl: one vector per clock
// cycle with hand-computed outputs, plus an asynchronous reset sequence.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;

  logic        CLK, nRST;
  logic [1:0]  dREN, dWEN, cctrans, ccwrite;
  logic [63:0] daddr, dstore;
  logic [1:0]  dwait;
  logic [63:0] dload;
  logic [1:0]  ccwait, ccinv;
  logic [63:0] ccsnoopaddr;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic        ram_ready;

  int checks   = 0;
  int failures = 0;

  coherence_bus_ctrl #(.RAM_LAT(0)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans),
    .ccwrite(ccwrite), .daddr(daddr), .dstore(dstore), .dwait(dwait),
    .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  dren, dwen, cct, ccw;
    logic [31:0] a1, a0, s1, s0, ld;
    logic        rdy;
    logic [1:0]  e_dwait, e_ccwait, e_ccinv;
    logic [31:0] e_snp1, e_snp0;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic [1:0] dren, dwen, cct, ccw,
    input logic [31:0] a1, a0, s1, s0, ld, input logic rdy,
    input logic [1:0] e_dwait, e_ccwait, e_ccinv,
    input logic [31:0] e_snp1, e_snp0, input logic e_ren, e_wen,
    input logic [31:0] e_addr, e_store);
    vec_t v;
    v.dren = dren; v.dwen = dwen; v.cct = cct; v.ccw = ccw;
    v.a1 = a1; v.a0 = a0; v.s1 = s1; v.s0 = s0; v.ld = ld; v.rdy = rdy;
    v.e_dwait = e_dwait; v.e_ccwait = e_ccwait; v.e_ccinv = e_ccinv;
    v.e_snp1 = e_snp1; v.e_snp0 = e_snp0; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_store = e_store;
    return v;
  endfunction

  // Inputs with the quiet (IDLE / reset) output pattern expected.
  function automatic vec_t mki(
    input logic [1:0] dren, dwen, cct, ccw,
    input logic [31:0] a1, a0, s1, s0, ld, input logic rdy);
    return mk(dren, dwen, cct, ccw, a1, a0, s1, s0, ld, rdy,
              2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b0, 1'b0, 'h0, 'h0);
  endfunction

  task automatic drive(input vec_t v);
    dREN = v.dren; dWEN = v.dwen; cctrans = v.cct; ccwrite = v.ccw;
    daddr = {v.a1, v.a0}; dstore = {v.s1, v.s0};
    ram_load = v.ld; ram_ready = v.rdy;
  endtask

  task automatic check(input vec_t v, input string nm);
    logic [199:0] act, exp;
    act = {dwait, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store, dload};
    exp = {v.e_dwait, v.e_ccwait, v.e_ccinv, v.e_snp1, v.e_snp0, v.e_ren, v.e_wen,
           v.e_addr, v.e_store, v.ld, v.ld};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge CLK);
    drive(v);
    #1;
    check(v, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // Cache0 read miss 0x100, cache1 clean: 2 snoop cycles then 2 reads.
    tv.push_back(mki(2'b01,2'b00,2'b01,2'b00,'h0,'h100,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b01,2'b00,2'b01,2'b00,'h0,'h100,'h0,'h0,'h0,1'b1, 2'b11,2'b10,2'b00,'h100,'h0,1'b0,1'b0,'h0,'h0));
    tv.push_back(mk(2'b01,2'b00,2'b01,2'b00,'h0,'h100,'h0,'h0,'h0,1'b1, 2'b11,2'b10,2'b00,'h100,'h0,1'b0,1'b0,'h0,'h0));
    tv.push_back(mk(2'b01,2'b00,2'b01,2'b00,'h0,'h100,'h0,'h0,'h1111,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h100,'h0));
    tv.push_back(mk(2'b01,2'b00,2'b01,2'b00,'h0,'h104,'h0,'h0,'h2222,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h104,'h0));
    // Cache1 write miss 0x200, cache0 dirty: invalidate, writeback, then read.
    tv.push_back(mki(2'b10,2'b00,2'b10,2'b10,'h200,'h0,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b10,2'b00,2'b10,2'b11,'h200,'h0,'h0,'h0,'h0,1'b1, 2'b11,2'b01,2'b01,'h0,'h200,1'b0,1'b0,'h0,'h0));
    tv.push_back(mk(2'b10,2'b00,2'b10,2'b11,'h200,'h0,'h0,'h0,'h0,1'b1, 2'b11,2'b01,2'b01,'h0,'h200,1'b0,1'b0,'h0,'h0));
    tv.push_back(mk(2'b10,2'b01,2'b10,2'b11,'h200,'h200,'h0,'hAAAA,'h0,1'b1, 2'b10,2'b01,2'b01,'h0,'h200,1'b0,1'b1,'h200,'hAAAA));
    tv.push_back(mk(2'b10,2'b01,2'b10,2'b11,'h200,'h204,'h0,'hBBBB,'h0,1'b1, 2'b10,2'b01,2'b01,'h0,'h200,1'b0,1'b1,'h204,'hBBBB));
    tv.push_back(mk(2'b10,2'b00,2'b10,2'b00,'h200,'h0,'h0,'h0,'hAAAA,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h200,'h0));
    tv.push_back(mk(2'b10,2'b00,2'b10,2'b00,'h204,'h0,'h0,'h0,'hBBBB,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h204,'h0));
    // Simultaneous plain reads: round-robin 0,1,0 then lone cache1.
    tv.push_back(mki(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h400,'h0));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h500,'h404,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h404,'h0));
    tv.push_back(mki(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h500,'h0));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h504,'h400,'h0,'h0,'h0,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h504,'h0));
    tv.push_back(mki(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h500,'h400,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h400,'h0));
    tv.push_back(mk(2'b11,2'b00,2'b00,2'b00,'h500,'h404,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h404,'h0));
    tv.push_back(mki(2'b10,2'b00,2'b00,2'b00,'h500,'h0,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b10,2'b00,2'b00,2'b00,'h500,'h0,'h0,'h0,'h0,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h500,'h0));
    tv.push_back(mk(2'b10,2'b00,2'b00,2'b00,'h504,'h0,'h0,'h0,'h0,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h504,'h0));
    // Cache0 eviction writeback 0x300, RAM ready after 3 wait cycles per word.
    tv.push_back(mki(2'b00,2'b01,2'b00,2'b00,'h0,'h300,'h0,'h1234,'h0,1'b0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(2'b00,2'b01,2'b00,2'b00,'h0,'h300,'h0,'h1234,'h0,1'b0, 2'b11,2'b00,2'b00,'h0,'h0,1'b0,1'b1,'h300,'h1234));
    tv.push_back(mk(2'b00,2'b01,2'b00,2'b00,'h0,'h300,'h0,'h1234,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b0,1'b1,'h300,'h1234));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(2'b00,2'b01,2'b00,2'b00,'h0,'h304,'h0,'h5678,'h0,1'b0, 2'b11,2'b00,2'b00,'h0,'h0,1'b0,1'b1,'h304,'h5678));
    tv.push_back(mk(2'b00,2'b01,2'b00,2'b00,'h0,'h304,'h0,'h5678,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b0,1'b1,'h304,'h5678));
    // Cache1 single-word store with cctrans high: no snoop, early return to IDLE.
    tv.push_back(mki(2'b00,2'b10,2'b10,2'b00,'h600,'h0,'h9999,'h0,'h0,1'b1));
    tv.push_back(mk(2'b00,2'b10,2'b10,2'b00,'h600,'h0,'h9999,'h0,'h0,1'b1, 2'b01,2'b00,2'b00,'h0,'h0,1'b0,1'b1,'h600,'h9999));
    tv.push_back(mk(2'b00,2'b00,2'b10,2'b00,'h600,'h0,'h9999,'h0,'h0,1'b0, 2'b11,2'b00,2'b00,'h0,'h0,1'b0,1'b0,'h600,'h9999));
    // Cache0 with dREN and dWEN together is serviced as a full two-word read.
    tv.push_back(mki(2'b01,2'b01,2'b00,2'b00,'h0,'h700,'h0,'h0,'h0,1'b1));
    tv.push_back(mk(2'b01,2'b01,2'b00,2'b00,'h0,'h700,'h0,'h0,'h3333,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h700,'h0));
    tv.push_back(mk(2'b01,2'b01,2'b00,2'b00,'h0,'h704,'h0,'h0,'h4444,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h704,'h0));
    tv.push_back(mki(2'b00,2'b00,2'b00,2'b00,'h0,'h0,'h0,'h0,'h0,1'b1));

    // Reset state with active inputs.
    nRST = 1'b0;
    v = mki(2'b11,2'b11,2'b11,2'b11,'h500,'h400,'h55,'h44,'hCAFE,1'b1);
    drive(v);
    repeat (2) @(negedge CLK);
    #1 check(v, "reset_state");
    @(negedge CLK);
    nRST = 1'b1;
    drive(mki(2'b00,2'b00,2'b00,2'b00,'h0,'h0,'h0,'h0,'h0,1'b0));

    foreach (tv[i]) step(tv[i], $sformatf("vec%0d", i));

    // Asynchronous reset during the first XFER word, then re-arbitration.
    step(mki(2'b01,2'b00,2'b00,2'b00,'h0,'h800,'h0,'h0,'h0,1'b1), "rst_seq_idle");
    step(mk(2'b01,2'b00,2'b00,2'b00,'h0,'h800,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h800,'h0), "rst_seq_xfer");
    #2 nRST = 1'b0;
    v = mki(2'b01,2'b00,2'b00,2'b00,'h0,'h800,'h0,'h0,'h0,1'b1);
    #1 check(v, "rst_async");
    @(negedge CLK);
    #1 check(v, "rst_held");
    @(negedge CLK);
    nRST = 1'b1;
    v = mki(2'b11,2'b00,2'b00,2'b00,'h900,'h800,'h0,'h0,'h0,1'b1);
    drive(v);
    #1 check(v, "rst_release_idle");
    step(mk(2'b11,2'b00,2'b00,2'b00,'h900,'h800,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h800,'h0), "rst_rearb_w1");
    step(mk(2'b11,2'b00,2'b00,2'b00,'h900,'h804,'h0,'h0,'h0,1'b1, 2'b10,2'b00,2'b00,'h0,'h0,1'b1,1'b0,'h804,'h0), "rst_rearb_w2");
    step(mki(2'b00,2'b00,2'b00,2'b00,'h0,'h0,'h0,'h0,'h0,1'b1), "rst_end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
